// File: rtl/derivative_estimator.sv
// Windowed finite-difference estimator: (x[n] - x[n-D]) * 256 / (D * interval)
// as a signed Q24.8 rate, computed with a multi-cycle restoring divider.
module derivative_estimator #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid_i,
  input  logic [DATA_W-1:0] ADC_data_i,
  input  logic [7:0]        duration_i,
  input  logic [7:0]        interval_i,
  output logic              busy_o,
  output logic              deriv_valid_o,
  output logic [31:0]       derivative_o,
  output logic              div_err_o,
  output logic              overrun_o
);

  localparam int DIV_W = DATA_W + 8;
  localparam int DEN_W = 16;
  localparam int CNT_W = $clog2(DIV_W);
  localparam logic [7:0] MAX_D = 8'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

  state_t             state_q;
  logic [DATA_W-1:0]  histMem [DEPTH];
  logic [ADDR_W-1:0]  wrPtr_q;
  logic [ADDR_W:0]    fill_q;
  logic [ADDR_W:0]    fillBefore_q;
  logic [DATA_W-1:0]  xNew_q;
  logic [DATA_W-1:0]  xOld_q;
  logic [ADDR_W-1:0]  dEff_q;
  logic [7:0]         interval_q;
  logic               sign_q;
  logic [DIV_W-1:0]   dividend_q;
  logic [DEN_W-1:0]   den_q;
  logic [DEN_W-1:0]   rem_q;
  logic [CNT_W-1:0]   iter_q;
  logic               derivValid_q;
  logic [31:0]        derivative_q;
  logic               divErr_q;
  logic               overrun_q;

  logic              accept;
  logic [ADDR_W-1:0] dEff_d;
  logic [ADDR_W-1:0] rdAddr;
  logic [ADDR_W:0]   fill_d;
  logic [DATA_W-1:0] diffMag;
  logic              diffNeg;
  logic [DEN_W-1:0]  den_d;
  logic [DEN_W:0]    trial;
  logic              trialGe;
  logic [DEN_W-1:0]  trialSub;

  assign accept  = (state_q == IDLE) && sample_valid_i;
  assign dEff_d  = (duration_i > MAX_D) ? ADDR_W'(MAX_D) : duration_i[ADDR_W-1:0];
  assign rdAddr  = wrPtr_q - dEff_d;
  assign fill_d  = (fill_q == (ADDR_W+1)'(DEPTH)) ? fill_q : fill_q + 1'b1;

  assign diffNeg = xNew_q < xOld_q;
  assign diffMag = diffNeg ? (xOld_q - xNew_q) : (xNew_q - xOld_q);
  assign den_d   = DEN_W'(dEff_q) * DEN_W'(interval_q);

  // Remainder stays below the divisor, so the subtraction fits in DEN_W bits.
  assign trial    = {rem_q, dividend_q[DIV_W-1]};
  assign trialGe  = trial >= {1'b0, den_q};
  assign trialSub = trial[DEN_W-1:0] - den_q;

  // History storage is deliberately not reset; fill_q gates every read.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      histMem[wrPtr_q] <= ADC_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wrPtr_q      <= '0;
      fill_q       <= '0;
      fillBefore_q <= '0;
      xNew_q       <= '0;
      xOld_q       <= '0;
      dEff_q       <= '0;
      interval_q   <= '0;
      sign_q       <= 1'b0;
      dividend_q   <= '0;
      den_q        <= '0;
      rem_q        <= '0;
      iter_q       <= '0;
      derivValid_q <= 1'b0;
      derivative_q <= '0;
      divErr_q     <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      derivValid_q <= 1'b0;
      overrun_q    <= sample_valid_i && (state_q != IDLE);
      unique case (state_q)
        IDLE: begin
          if (sample_valid_i) begin
            wrPtr_q      <= wrPtr_q + 1'b1;
            fill_q       <= fill_d;
            fillBefore_q <= fill_q;
            xNew_q       <= ADC_data_i;
            xOld_q       <= histMem[rdAddr];
            dEff_q       <= dEff_d;
            interval_q   <= interval_i;
            state_q      <= LOAD;
          end
        end
        LOAD: begin
          if (dEff_q == '0 || interval_q == '0) begin
            derivative_q <= '0;
            divErr_q     <= 1'b1;
            derivValid_q <= 1'b1;
            state_q      <= IDLE;
          end else if (fillBefore_q < {1'b0, dEff_q}) begin
            derivative_q <= '0;
            divErr_q     <= 1'b0;
            derivValid_q <= 1'b1;
            state_q      <= IDLE;
          end else begin
            den_q      <= den_d;
            dividend_q <= {diffMag, 8'h00};
            sign_q     <= diffNeg;
            rem_q      <= '0;
            iter_q     <= CNT_W'(DIV_W - 1);
            state_q    <= DIV;
          end
        end
        DIV: begin
          // The dividend shifts out MSB-first while quotient bits shift in.
          rem_q      <= trialGe ? trialSub : trial[DEN_W-1:0];
          dividend_q <= {dividend_q[DIV_W-2:0], trialGe};
          if (iter_q == '0) begin
            state_q <= DONE;
          end else begin
            iter_q <= iter_q - 1'b1;
          end
        end
        DONE: begin
          derivative_q <= sign_q ? -32'(dividend_q) : 32'(dividend_q);
          divErr_q     <= 1'b0;
          derivValid_q <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o        = (state_q != IDLE);
  assign deriv_valid_o = derivValid_q;
  assign derivative_o  = derivative_q;
  assign div_err_o     = divErr_q;
  assign overrun_o     = overrun_q;

endmodule

// File: doc/derivative_estimator.md
Name: derivative_estimator

Overview:
Windowed finite-difference (discrete derivative) estimator for the ADC sample stream. It is the inverse operation to the team's windowed integrator, and together they form the I and D terms of the controller. The block keeps a circular history of samples and computes (x[n] - x[n-D]) * 256 / (D * interval) as a signed Q8 fixed-point rate. It uses a multi-cycle restoring divider. It sits between the ADC capture logic and the control-law summer.

Parameters:
DATA_W, 16, ADC sample width (unsigned)
DEPTH, 32, history buffer depth in samples (power of two)
ADDR_W, 5, log2(DEPTH)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
sample_valid  input  1  ADC_data holds a new sample this cycle
ADC_data  input  DATA_W  unsigned ADC sample
duration  input  8  window length D in samples, sampled on accept
interval  input  8  sample period in ticks, sampled on accept
busy  output  1  high whenever state != IDLE
deriv_valid  output  1  one-cycle pulse; derivative/div_err valid
derivative  output  32  signed Q24.8 rate estimate, held between pulses
div_err  output  1  zero divisor on last result; updates with deriv_valid
overrun  output  1  one-cycle pulse; sample offered while busy, dropped

Behaviour:
- Reset, which is synchronous, active-high on clk: busy=0, deriv_valid=0, derivative=0, div_err=0, overrun=0. Also wr_ptr=0, fill=0, state=IDLE. Buffer contents are not cleared; fill=0 guarantees stale data is never read.
- States: IDLE, LOAD, DIV, DONE. busy=1 in LOAD/DIV/DONE.
- Accept, at edge 0 (IDLE and sample_valid):
  - mem[wr_ptr] <= ADC_data; wr_ptr <= wr_ptr+1 (mod DEPTH).
  - fill <= min(fill+1, DEPTH).
  - Latch x_new=ADC_data and D_eff = min(duration, DEPTH-1).
  - Latch x_old = mem[(wr_ptr - D_eff) mod DEPTH] (pre-write contents), plus fill_before=fill and interval.
  - Go to LOAD.
- sample_valid while busy: sample not written, no state change, overrun=1 for the following cycle.
- LOAD, at edge 1:
  - If D_eff==0 or interval==0: derivative<=0, div_err<=1, deriv_valid<=1, go to IDLE.
  - Else if fill_before < D_eff (insufficient history): derivative<=0, div_err<=0, deriv_valid<=1, go to IDLE.
  - Else: diff = x_new - x_old as 17-bit signed; den = D_eff*interval (16-bit unsigned, max 7905); dividend = |diff| << 8 (24-bit unsigned); record sign; clear remainder and quotient; iter=23; go to DIV.
- DIV: restoring division, one quotient bit per edge, MSB first, over edges 2..25 (24 iterations). On iter==0 go to DONE.
- DONE, at edge 26:
  - derivative <= sign ? -quotient : quotient, sign-extended to 32 bits (truncation toward zero).
  - div_err<=0, deriv_valid<=1, go to IDLE.
- Latency from the accepting edge: normal path, deriv_valid high after edge 26; shortcut paths, high after edge 1.
- A new sample may be accepted in the same cycle deriv_valid is high, since the state is already IDLE.
- deriv_valid and overrun are single-cycle pulses. derivative and div_err hold until the next result.
- Wrap-around: pointer arithmetic is modulo DEPTH. fill saturates at DEPTH. After saturation, any D_eff ≤ DEPTH-1 is always valid.
- Magnitude bound: |result| ≤ 65535*256 < 2^24, so there is no overflow in 32 bits.
- Reset mid-operation (any state): immediate return to reset values at that edge. No deriv_valid pulse for the aborted sample; the history is discarded (fill=0).
- duration and interval changes while busy do not affect the in-flight computation.

Test Plan:
1. Reset asserted for 2 cycles -> all outputs 0, busy 0. Then 3 samples with duration=4 -> each gives deriv_valid at edge 1, derivative=0, div_err=0.
2. Ramp 0,10,20,...,60, duration=4, interval=2 (7th sample, x_new=60, x_old=20) -> diff=40, den=8, derivative=1280, deriv_valid exactly 26 edges after accept.
3. Descending ramp 1000,990,...; duration=4, interval=2 -> derivative=-1280 (32'hFFFFFB00). Step of +1 with duration=1, interval=3 -> 85; step of -1 -> -85.
4. duration=0 -> div_err=1, derivative=0 after edge 1. interval=0 -> same. duration=40 with a full buffer -> D_eff=31 (x_old from 31 samples back).
5. 40 samples of a ramp step 2, then duration=31, interval=1 -> pointer wrap verified, derivative=512. sample_valid held every cycle -> exactly 1 accept per 27 cycles, overrun pulses on the other 26 cycles.
6. Reset asserted at edge 10 (mid-DIV) -> busy=0 next cycle, no deriv_valid. The next sample then takes the insufficient-history path (derivative=0).
